// File: rtl/intersection_ctrl.sv
// ---------------------------------------------------------------------------
// intersection_ctrl
//   Two-approach (NS/EW) intersection sequencer. The NS green is actuated:
//   it holds between a minimum and maximum time and is cut short once EW
//   demand or a pending pedestrian request exists. Pedestrian requests are
//   latched and served in an extended all-red walk phase.
//
//   Optional feature: define EMERG_PREEMPT_EN to add the emerg input and the
//   PRE (emergency all-red hold) state. Without it PRE is unreachable.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   ped_req   in   pedestrian request (level or pulse, sampled every clk)
//   ew_car    in   EW vehicle detector (level)
//   emerg     in   emergency preempt (level, EMERG_PREEMPT_EN only)
//   ns_light  out  NS head {red,yellow,green}
//   ew_light  out  EW head {red,yellow,green}
//   ped_walk  out  walk indication
//   phase     out  current state code
// ---------------------------------------------------------------------------
module intersection_ctrl #(
   parameter int TW         = 8,
   parameter int RED_CLR_T  = 2,
   parameter int NS_MIN_T   = 10,
   parameter int NS_MAX_T   = 30,
   parameter int EW_GREEN_T = 10,
   parameter int YELLOW_T   = 5,
   parameter int WALK_T     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       ew_car,
`ifdef EMERG_PREEMPT_EN
   input  logic       emerg,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       ped_walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      ARA = 3'd0, NSG = 3'd1, NSY = 3'd2, ARB = 3'd3,
      EWG = 3'd4, EWY = 3'd5, PRE = 3'd6
   } state_t;

   // Terminal counts: a state of duration D exits when cnt == D-1.
   localparam logic [TW-1:0] RED_END    = TW'(RED_CLR_T - 1);
   localparam logic [TW-1:0] WALK_END   = TW'(WALK_T - 1);
   localparam logic [TW-1:0] NS_MIN_END = TW'(NS_MIN_T - 1);
   localparam logic [TW-1:0] NS_MAX_END = TW'(NS_MAX_T - 1);
   localparam logic [TW-1:0] EWG_END    = TW'(EW_GREEN_T - 1);
   localparam logic [TW-1:0] YEL_END    = TW'(YELLOW_T - 1);

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   state_t          state_q, state_d;
   logic [TW-1:0]   cnt_q;
   logic [TW-1:0]   clr_end_s;
   logic            walk_q, walk_d;
   logic            ped_pend_q, ped_pend_d;
   logic            preempt_q, preempt_d;
   logic            emerg_s;
   logic [2:0]      ns_light_q, ew_light_q;

`ifdef EMERG_PREEMPT_EN
   assign emerg_s = emerg;
`else
   assign emerg_s = 1'b0;
`endif

   // Head decode {ns,ew}; anything other than a green/yellow state is all-red,
   // so two greens can never be shown together.
   function automatic logic [5:0] light_decode(input state_t s);
      case (s)
         NSG:     light_decode = {L_GRN, L_RED};
         NSY:     light_decode = {L_YEL, L_RED};
         EWG:     light_decode = {L_RED, L_GRN};
         EWY:     light_decode = {L_RED, L_YEL};
         default: light_decode = {L_RED, L_RED};
      endcase
   endfunction

   // Next-state, pedestrian latch, walk flag and preempt memory.
   always_comb begin
      state_d   = state_q;
      preempt_d = preempt_q;
      clr_end_s = walk_q ? WALK_END : RED_END;
      if (ped_req && !walk_q) begin
         ped_pend_d = 1'b1;
      end else begin
         ped_pend_d = ped_pend_q;
      end

      case (state_q)
         ARA: begin
            if (emerg_s) begin
               state_d    = PRE;
               ped_pend_d = ped_pend_d | walk_q;   // aborted walk is re-requested
            end else if (cnt_q == clr_end_s) begin
               state_d = NSG;
            end else begin
               state_d = ARA;
            end
         end
         NSG: begin
            if (emerg_s) begin
               state_d   = NSY;
               preempt_d = 1'b1;
            end else if ((cnt_q == NS_MAX_END) ||
                         ((cnt_q >= NS_MIN_END) && (ew_car || ped_pend_q))) begin
               state_d = NSY;
            end else begin
               state_d = NSG;
            end
         end
         NSY: begin
            preempt_d = preempt_q | emerg_s;
            if (cnt_q == YEL_END) begin
               state_d = (preempt_q || emerg_s) ? PRE : ARB;
            end else begin
               state_d = NSY;
            end
         end
         ARB: begin
            if (emerg_s) begin
               state_d    = PRE;
               ped_pend_d = ped_pend_d | walk_q;
            end else if (cnt_q == clr_end_s) begin
               state_d = EWG;
            end else begin
               state_d = ARB;
            end
         end
         EWG: begin
            if (emerg_s) begin
               state_d   = EWY;
               preempt_d = 1'b1;
            end else if (cnt_q == EWG_END) begin
               state_d = EWY;
            end else begin
               state_d = EWG;
            end
         end
         EWY: begin
            preempt_d = preempt_q | emerg_s;
            if (cnt_q == YEL_END) begin
               state_d = (preempt_q || emerg_s) ? PRE : ARA;
            end else begin
               state_d = EWY;
            end
         end
`ifdef EMERG_PREEMPT_EN
         PRE: begin
            if (emerg_s) begin
               state_d = PRE;
            end else begin
               state_d = ARA;
            end
         end
`endif
         default: state_d = ARA;   // illegal code recovers to all-red
      endcase

      // Entering an all-red phase with a pending request turns it into a walk.
      if (state_d != state_q) begin
         if ((state_d == ARA) || (state_d == ARB)) begin
            walk_d     = ped_pend_d;
            ped_pend_d = 1'b0;
         end else begin
            walk_d = 1'b0;
         end
      end else begin
         walk_d = walk_q;
      end

      if (state_d == PRE) begin
         preempt_d = 1'b0;
      end else begin
         preempt_d = preempt_d;
      end
   end

   // State, elapsed counter and registered head outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARA;
         cnt_q      <= '0;
         walk_q     <= 1'b0;
         ped_pend_q <= 1'b0;
         preempt_q  <= 1'b0;
         ns_light_q <= L_RED;
         ew_light_q <= L_RED;
      end else begin
         state_q    <= state_d;
         cnt_q      <= (state_d != state_q) ? '0 : cnt_q + TW'(1);
         walk_q     <= walk_d;
         ped_pend_q <= ped_pend_d;
         preempt_q  <= preempt_d;
         {ns_light_q, ew_light_q} <= light_decode(state_d);
      end
   end

   assign ns_light = ns_light_q;
   assign ew_light = ew_light_q;
   assign ped_walk = walk_q;
   assign phase    = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;

   logic       clk;
   logic       reset;
   logic       ped_req;
   logic       ew_car;
   logic       emerg;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       ped_walk;
   logic [2:0] phase;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [2:0] ph;
      logic       walk;
   } exp_t;

   exp_t exp_q[$];

   intersection_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .ped_req  (ped_req),
      .ew_car   (ew_car),
`ifdef EMERG_PREEMPT_EN
      .emerg    (emerg),
`endif
      .ns_light (ns_light),
      .ew_light (ew_light),
      .ped_walk (ped_walk),
      .phase    (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {ns,ew} head values for a phase code.
   function automatic logic [5:0] exp_lights(input logic [2:0] ph);
      case (ph)
         3'd1:    exp_lights = {3'b001, 3'b100};
         3'd2:    exp_lights = {3'b010, 3'b100};
         3'd4:    exp_lights = {3'b100, 3'b001};
         3'd5:    exp_lights = {3'b100, 3'b010};
         default: exp_lights = {3'b100, 3'b100};
      endcase
   endfunction

   task automatic push_seg(input logic [2:0] ph, input int n, input logic walk);
      exp_t e;
      e.ph   = ph;
      e.walk = walk;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic drive(input int tid, input int cyc);
      ped_req = 1'b0;
      ew_car  = 1'b0;
      emerg   = 1'b0;
      case (tid)
         2: ew_car = 1'b1;
         3: ped_req = (cyc == 5) || (cyc == 20);
         5: emerg = (cyc >= 20) && (cyc < 40);
         6: begin
            ew_car  = (cyc == 20);
            ped_req = (cyc == 20);
         end
         default: ;
      endcase
   endtask

   task automatic check_heads(input string tag);
      check_eq({tag, "_ns_onehot"}, int'($onehot(ns_light)), 1);
      check_eq({tag, "_ew_onehot"}, int'($onehot(ew_light)), 1);
      check_eq({tag, "_conflict"}, int'((ns_light != 3'b100) && (ew_light != 3'b100)), 0);
   endtask

   // Called at a falling edge: cycle n is observed before rising edge n.
   task automatic run(input int tid, input string tag);
      int cyc = 0;
      exp_t e;
      logic [5:0] l;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         l = exp_lights(e.ph);
         drive(tid, cyc);
         check_eq({tag, "_phase"}, int'(phase), int'(e.ph));
         check_eq({tag, "_walk"}, int'(ped_walk), int'(e.walk));
         check_eq({tag, "_ns"}, int'(ns_light), int'(l[5:3]));
         check_eq({tag, "_ew"}, int'(ew_light), int'(l[2:0]));
         check_heads(tag);
         @(negedge clk);
         cyc++;
      end
      drive(0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_phase"}, int'(phase), 0);
      check_eq({tag, "_ns"}, int'(ns_light), 3'b100);
      check_eq({tag, "_ew"}, int'(ew_light), 3'b100);
      check_eq({tag, "_walk"}, int'(ped_walk), 0);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0);
      #1;
      check_reset_state("rst0");

      // No demand: full natural cycle, period 54.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 30, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd3, 2, 1'b0);  push_seg(3'd4, 10, 1'b0); push_seg(3'd5, 5, 1'b0);
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 3, 1'b0);
      run(1, "idle");

      // Continuous EW demand: NS green held to its minimum.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 10, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd3, 2, 1'b0);  push_seg(3'd4, 10, 1'b0); push_seg(3'd5, 5, 1'b0);
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 1, 1'b0);
      run(2, "ewcar");

      // Pedestrian pulse at 5 served in ARB; pulse at 20 during walk ignored.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 10, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd3, 8, 1'b1);  push_seg(3'd4, 10, 1'b0); push_seg(3'd5, 5, 1'b0);
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 30, 1'b0); push_seg(3'd2, 1, 1'b0);
      run(3, "ped");

      // Same-cycle ped and car after the minimum: immediate yellow, one walk in ARB.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 19, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd3, 8, 1'b1);  push_seg(3'd4, 10, 1'b0); push_seg(3'd5, 5, 1'b0);
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 1, 1'b0);
      run(6, "pedcar");

      // Asynchronous reset in the middle of EW green.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 30, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd3, 2, 1'b0);  push_seg(3'd4, 5, 1'b0);
      run(4, "pre_rst");
      check_eq("midrst_before_ew", int'(ew_light), 3'b001);
      reset = 1'b1;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 2, 1'b0);
      run(4, "post_rst");

`ifdef EMERG_PREEMPT_EN
      // Emergency in NS green: yellow completes, PRE held, then normal ARA.
      do_reset();
      push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 19, 1'b0); push_seg(3'd2, 5, 1'b0);
      push_seg(3'd6, 15, 1'b0); push_seg(3'd0, 2, 1'b0);  push_seg(3'd1, 1, 1'b0);
      run(5, "emerg");
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
